// File: rtl/key_scan_pkg.sv
// key_scan_pkg
// Shared types, constants and the round-robin selector for the key scan
// debounce controller.
//   scan_state_e : controller FSM states (IDLE, DEB, EMIT)
//   EVT_PRESS / EVT_RELEASE : encoding of Evt_Type
//   rr_pick()    : first set bit of a change vector, searched from last+1
//                  with wrap-around inside n_keys
package key_scan_pkg;

    localparam int MAX_KEYS = 16;
    localparam int IDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEB  = 2'd1,
        EMIT = 2'd2
    } scan_state_e;

    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    // Scans n_keys positions starting one past 'last'. Because last < n_keys
    // and k <= n_keys, one conditional subtract is enough for the wrap, which
    // keeps the logic free of a modulo divider. Returns 'last' if nothing set.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_KEYS-1:0] diff,
        input logic [IDX_W-1:0]    last,
        input int                  n_keys
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_KEYS; k++) begin
            idx = int'(last) + k;
            if (idx >= n_keys) begin
                idx = idx - n_keys;
            end
            if (!found && (k <= n_keys) && diff[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/key_scan_ctrl_key_sync.sv
// key_sync
// N-bit two-flop synchroniser for asynchronous key levels.
//   clk  : sampling clock
//   srst : synchronous active-high reset, clears both flop stages
//   d    : raw asynchronous inputs
//   q    : inputs delayed by two clock cycles
module key_sync #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta_reg;
    logic [N-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (srst) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl
// Debounces N_KEYS pushbuttons with one shared counter. Keys whose
// synchronised level differs from their stable level are served one at a
// time, round-robin; a change held for DEB_CYCLES cycles flips the stable
// level and is reported as a press/release event on a valid/ready port.
//   Sys_CLK   : system clock
//   Sys_RST   : synchronous active-high reset
//   Key_In    : raw key levels (1 = pressed)
//   Key_State : debounced stable levels
//   Evt_Valid / Evt_Ready : event handshake
//   Evt_Key   : index of the key that changed
//   Evt_Type  : 1 = press, 0 = release
//   Busy      : controller is debouncing or holding an event
module key_scan_ctrl
    import key_scan_pkg::*;
#(
    parameter int    N_KEYS     = 2,
    parameter int    DEB_CYCLES = 500_000,
    localparam int   CNT_W      = $clog2(DEB_CYCLES),
    localparam int   KEY_W      = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              Sys_CLK,
    input  logic              Sys_RST,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_State,
    output logic              Evt_Valid,
    input  logic              Evt_Ready,
    output logic [KEY_W-1:0]  Evt_Key,
    output logic              Evt_Type,
    output logic              Busy
);

    logic [N_KEYS-1:0] sync;
    logic [N_KEYS-1:0] diff;

    scan_state_e       state_reg,     state_next;
    logic [CNT_W-1:0]  cnt_reg,       cnt_next;
    logic [KEY_W-1:0]  sel_reg,       sel_next;
    logic [KEY_W-1:0]  last_reg,      last_next;
    logic [N_KEYS-1:0] key_state_reg, key_state_next;
    logic              evt_valid_reg, evt_valid_next;
    logic [KEY_W-1:0]  evt_key_reg,   evt_key_next;
    logic              evt_type_reg,  evt_type_next;

    key_sync #(
        .N (N_KEYS)
    ) u_key_sync (
        .clk  (Sys_CLK),
        .srst (Sys_RST),
        .d    (Key_In),
        .q    (sync)
    );

    // Keys whose synchronised level disagrees with their stable level.
    assign diff = sync ^ key_state_reg;

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sel_reg       <= '0;
            // Start one before key 0 so the first pick begins at key 0.
            last_reg      <= KEY_W'(N_KEYS - 1);
            key_state_reg <= '0;
            evt_valid_reg <= 1'b0;
            evt_key_reg   <= '0;
            evt_type_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sel_reg       <= sel_next;
            last_reg      <= last_next;
            key_state_reg <= key_state_next;
            evt_valid_reg <= evt_valid_next;
            evt_key_reg   <= evt_key_next;
            evt_type_reg  <= evt_type_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sel_next       = sel_reg;
        last_next      = last_reg;
        key_state_next = key_state_reg;
        evt_valid_next = evt_valid_reg;
        evt_key_next   = evt_key_reg;
        evt_type_next  = evt_type_reg;

        case (state_reg)
            IDLE: begin
                if (|diff) begin
                    sel_next   = KEY_W'(rr_pick(MAX_KEYS'(diff), IDX_W'(last_reg), N_KEYS));
                    cnt_next   = '0;
                    state_next = DEB;
                end
            end
            DEB: begin
                // Only the selected key is watched; any reversion aborts
                // without touching 'last', so the same key is retried first.
                if (sync[sel_reg] == key_state_reg[sel_reg]) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                    key_state_next[sel_reg] = ~key_state_reg[sel_reg];
                    evt_key_next            = sel_reg;
                    evt_type_next           = key_state_reg[sel_reg] ? EVT_RELEASE : EVT_PRESS;
                    evt_valid_next          = 1'b1;
                    last_next               = sel_reg;
                    state_next              = EMIT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            EMIT: begin
                if (evt_valid_reg && Evt_Ready) begin
                    evt_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Key_State = key_state_reg;
    assign Evt_Valid = evt_valid_reg;
    assign Evt_Key   = evt_key_reg;
    assign Evt_Type  = evt_type_reg;
    assign Busy      = (state_reg != IDLE);

endmodule
